vscale_mem_arbiter: RTL and testbench
=====================================

Name: vscale_mem_arbiter

Overview:
- Shares one pipelined single-port memory bus between the pipeline's instruction-fetch and data ports.
- Instantiated between the pipeline and the memory/bridge.
- Fixed data-over-instruction priority, with a starvation limit that forces a fetch grant.
- Tracks data-phase ownership so read data, wait and bus errors return to the requester that issued the address.

Parameters:
- XPR_LEN, 32, address/data width
- STARVE_LIMIT, 4, consecutive accepted data transfers allowed while a fetch is pending; range 1..15
- CNT_W, 4, width of the starvation counter; must satisfy STARVE_LIMIT <= 2**CNT_W-1

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- imem_req  in  1  fetch address valid
- imem_addr  in  XPR_LEN  fetch address
- imem_wait  out  1  fetch stall
- imem_rvalid  out  1  fetch data-phase complete
- imem_rdata  out  XPR_LEN  fetch read data
- imem_badmem_e  out  1  fetch bus error
- dmem_en  in  1  data address valid
- dmem_wen  in  1  data write
- dmem_size  in  3  MEM_TYPE size code
- dmem_addr  in  XPR_LEN  data address
- dmem_wdata_delayed  in  XPR_LEN  store data, presented in the data phase
- dmem_wait  out  1  data stall
- dmem_rvalid  out  1  data data-phase complete
- dmem_rdata  out  XPR_LEN  data read data
- dmem_badmem_e  out  1  data bus error
- mem_en  out  1  bus address valid
- mem_wen  out  1  bus write
- mem_size  out  3  bus size
- mem_addr  out  XPR_LEN  bus address
- mem_wdata  out  XPR_LEN  bus write data (data phase)
- mem_rdata  in  XPR_LEN  bus read data
- mem_wait  in  1  bus stall, extends the current data phase and freezes the address phase
- mem_badmem_e  in  1  bus error, valid in the data phase

Behaviour:

Bus protocol
- Two-stage pipelined bus: address phase in cycle N, data phase in cycle N+1, extended while mem_wait=1.
- An address is accepted when mem_en=1 and mem_wait=0.

State
- gnt_q: last address-phase grant, values NONE/IMEM/DMEM.
- dp_owner: current data-phase owner, values NONE/IMEM/DMEM.
- dp_wen: write flag of the current data phase.
- starve_cnt: CNT_W-bit counter.

Reset (reset_n=0, asynchronous)
- gnt_q=NONE, dp_owner=NONE, starve_cnt=0.
- All outputs 0 during reset.

Grant (combinational)
- If mem_wait=1 and gnt_q is still requesting, the grant is frozen to gnt_q so address outputs stay stable.
- Otherwise:
  - dmem wins if dmem_en=1, unless imem_req=1 and starve_cnt>=STARVE_LIMIT; then imem wins.
  - imem wins if only imem_req=1.
  - NONE if neither requests.
- gnt_q <= grant on every clock edge.

Address outputs
- mem_en, mem_wen, mem_size and mem_addr are muxed from the granted requester.
- Fetch grants drive mem_wen=0 and mem_size=MEM_TYPE_LW.
- No grant: all address outputs = 0.

Data phase
- On acceptance, dp_owner <= granted requester and dp_wen <= mem_wen.
- If mem_wait=0 and nothing is accepted, dp_owner <= NONE.
- mem_wdata = dmem_wdata_delayed when dp_owner=DMEM and dp_wen=1; otherwise 0.
- X_rvalid = (dp_owner==X) & ~mem_wait.
- X_rdata = mem_rdata when dp_owner==X; otherwise 0.
- X_badmem_e = mem_badmem_e & X_rvalid.

Wait outputs
- X_wait = (X requesting & not accepted this cycle) | (dp_owner==X & mem_wait).

Starvation counter
- Increments (saturating at 2**CNT_W-1) on each accepted dmem transfer while imem_req=1.
- Clears on an accepted imem transfer or when imem_req=0.

Boundary conditions
- Back-to-back accepted transfers from different owners: address phase of one overlaps the data phase of the other with no bubble.
- Requester drops its request while waiting: its grant is released next cycle; a data phase already in flight still completes to that requester.
- Reset asserted mid data phase: the transfer is abandoned, no rvalid is produced, and the bus returns idle immediately.

Optional Feature:
- Macro: VSCALE_MEM_ARB_RR_EN.
- Defined:
  - Fixed priority is replaced by round-robin: on a tie, the requester not granted in the last accepted transfer wins.
  - The starvation counter and STARVE_LIMIT are unused; starve_cnt is not implemented.
- Undefined: fixed dmem priority plus the starvation limit, as described above.

Test Plan:
1. Reset, then imem_req=1, addr=0x100, mem_wait=0 -> mem_addr=0x100 in cycle 1; imem_rvalid=1 with imem_rdata=mem_rdata in cycle 2; dmem_* outputs all 0.
2. imem_req and dmem_en both held, dmem load 0x2000 repeated, STARVE_LIMIT=4 -> bus grant sequence D,D,D,D,I,D...; imem_wait=1 for exactly 4 cycles.
3. dmem store 0x3004, wdata 0xDEADBEEF, mem_wait=1 for 2 data-phase cycles -> mem_wdata held at 0xDEADBEEF for 3 cycles; dmem_wait=1 for 2 cycles; next address frozen; dmem_rvalid for one cycle.
4. Accepted fetch followed by a data load in the next cycle -> data phases IMEM then DMEM with no bubble; rdata routed to the correct port each cycle.
5. mem_badmem_e=1 during a dmem data phase -> dmem_badmem_e=1 for that cycle only; imem_badmem_e=0.
6. reset_n deasserted mid data phase with mem_wait=1 -> all outputs 0 immediately; after release, first request is granted with no stale rvalid.

Source files
------------

// File: rtl/vscale_mem_arbiter.sv
// Arbitrates the fetch and data ports of the pipeline onto one pipelined single-port bus.
// Define VSCALE_MEM_ARB_RR_EN for round-robin tie-breaking instead of data priority with a starvation limit.
//
// owner       | meaning
// OWN_NONE    | no grant / no data phase in flight
// OWN_IMEM    | instruction-fetch port owns the address or data phase
// OWN_DMEM    | data port owns the address or data phase
module vscale_mem_arbiter #(
    parameter int XPR_LEN      = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               imem_req,
    input  logic [XPR_LEN-1:0] imem_addr,
    output logic               imem_wait,
    output logic               imem_rvalid,
    output logic [XPR_LEN-1:0] imem_rdata,
    output logic               imem_badmem_e,
    input  logic               dmem_en,
    input  logic               dmem_wen,
    input  logic [2:0]         dmem_size,
    input  logic [XPR_LEN-1:0] dmem_addr,
    input  logic [XPR_LEN-1:0] dmem_wdata_delayed,
    output logic               dmem_wait,
    output logic               dmem_rvalid,
    output logic [XPR_LEN-1:0] dmem_rdata,
    output logic               dmem_badmem_e,
    output logic               mem_en,
    output logic               mem_wen,
    output logic [2:0]         mem_size,
    output logic [XPR_LEN-1:0] mem_addr,
    output logic [XPR_LEN-1:0] mem_wdata,
    input  logic [XPR_LEN-1:0] mem_rdata,
    input  logic               mem_wait,
    input  logic               mem_badmem_e
);

    localparam logic [2:0] MEM_TYPE_LW = 3'd2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } owner_e;

    owner_e gnt_q, gnt_d, gnt_eff, tie_pick;
    owner_e dp_owner_q, dp_owner_d;
    logic   dp_wen_q, dp_wen_d;
    logic   gnt_held;
    logic   accept;
    logic   imem_dp, dmem_dp;

`ifdef VSCALE_MEM_ARB_RR_EN
    owner_e rr_last_q, rr_last_d;

    // On a tie the port that lost the most recent accepted transfer goes next.
    always_comb begin
        tie_pick  = (rr_last_q == OWN_DMEM) ? OWN_IMEM : OWN_DMEM;
        rr_last_d = rr_last_q;
        if (accept) begin
            rr_last_d = gnt_eff;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q <= OWN_NONE;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        tie_pick     = (starve_cnt_q >= CNT_LIMIT) ? OWN_IMEM : OWN_DMEM;
        starve_cnt_d = starve_cnt_q;
        if (!imem_req || (accept && gnt_eff == OWN_IMEM)) begin
            starve_cnt_d = '0;
        end else if (accept && gnt_eff == OWN_DMEM && starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // A stalled address phase keeps its grant so the bus sees stable address outputs.
    always_comb begin
        gnt_held = (gnt_q == OWN_IMEM && imem_req) || (gnt_q == OWN_DMEM && dmem_en);
        gnt_d    = OWN_NONE;
        if (mem_wait && gnt_held) begin
            gnt_d = gnt_q;
        end else if (dmem_en && imem_req) begin
            gnt_d = tie_pick;
        end else if (dmem_en) begin
            gnt_d = OWN_DMEM;
        end else if (imem_req) begin
            gnt_d = OWN_IMEM;
        end
        gnt_eff = reset_n ? gnt_d : OWN_NONE;
    end

    always_comb begin
        mem_en   = 1'b0;
        mem_wen  = 1'b0;
        mem_size = 3'd0;
        mem_addr = '0;
        case (gnt_eff)
            OWN_IMEM: begin
                mem_en   = 1'b1;
                mem_size = MEM_TYPE_LW;
                mem_addr = imem_addr;
            end
            OWN_DMEM: begin
                mem_en   = 1'b1;
                mem_wen  = dmem_wen;
                mem_size = dmem_size;
                mem_addr = dmem_addr;
            end
            default: ;
        endcase
    end

    assign accept = mem_en & ~mem_wait;

    always_comb begin
        dp_owner_d = dp_owner_q;
        dp_wen_d   = dp_wen_q;
        if (accept) begin
            dp_owner_d = gnt_eff;
            dp_wen_d   = mem_wen;
        end else if (!mem_wait) begin
            dp_owner_d = OWN_NONE;
            dp_wen_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q      <= OWN_NONE;
            dp_owner_q <= OWN_NONE;
            dp_wen_q   <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            dp_owner_q <= dp_owner_d;
            dp_wen_q   <= dp_wen_d;
        end
    end

    assign imem_dp = reset_n & (dp_owner_q == OWN_IMEM);
    assign dmem_dp = reset_n & (dp_owner_q == OWN_DMEM);

    assign mem_wdata = (dmem_dp && dp_wen_q) ? dmem_wdata_delayed : '0;

    assign imem_rvalid   = imem_dp & ~mem_wait;
    assign imem_rdata    = imem_dp ? mem_rdata : '0;
    assign imem_badmem_e = mem_badmem_e & imem_rvalid;

    assign dmem_rvalid   = dmem_dp & ~mem_wait;
    assign dmem_rdata    = dmem_dp ? mem_rdata : '0;
    assign dmem_badmem_e = mem_badmem_e & dmem_rvalid;

    assign imem_wait = reset_n & ((imem_req & ~(accept & (gnt_eff == OWN_IMEM)))
                                  | (imem_dp & mem_wait));
    assign dmem_wait = reset_n & ((dmem_en & ~(accept & (gnt_eff == OWN_DMEM)))
                                  | (dmem_dp & mem_wait));

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Self-checking bench for vscale_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_vscale_mem_arbiter;

    localparam int XL = 32;
    localparam int SL = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          imem_req = 1'b0;
    logic [XL-1:0] imem_addr = '0;
    logic          imem_wait, imem_rvalid, imem_badmem_e;
    logic [XL-1:0] imem_rdata;
    logic          dmem_en = 1'b0, dmem_wen = 1'b0;
    logic [2:0]    dmem_size = 3'd0;
    logic [XL-1:0] dmem_addr = '0, dmem_wdata_delayed = '0;
    logic          dmem_wait, dmem_rvalid, dmem_badmem_e;
    logic [XL-1:0] dmem_rdata;
    logic          mem_en, mem_wen;
    logic [2:0]    mem_size;
    logic [XL-1:0] mem_addr, mem_wdata;
    logic [XL-1:0] mem_rdata = '0;
    logic          mem_wait = 1'b0, mem_badmem_e = 1'b0;

    vscale_mem_arbiter #(.XPR_LEN(XL), .STARVE_LIMIT(SL), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_wait(imem_wait),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_badmem_e(imem_badmem_e),
        .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size), .dmem_addr(dmem_addr),
        .dmem_wdata_delayed(dmem_wdata_delayed), .dmem_wait(dmem_wait),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_badmem_e(dmem_badmem_e),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wait(mem_wait),
        .mem_badmem_e(mem_badmem_e)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: who held the last address-phase grant, which port's transfer is in its
    // data phase, and how many data transfers have been accepted while a fetch waited.
    int m_gnt = 0, m_dp = 0, m_starve = 0, m_rr = 0;
    bit m_dp_wen = 0;
    int n_gnt = 0, n_dp = 0, n_starve = 0, n_rr = 0;
    bit n_dp_wen = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_compare();
        int g;
        bit held, acc, ewen, tie_i;
        logic [2:0]    esize;
        logic [XL-1:0] eaddr;
        if (!reset_n) begin
            chk("rst_outputs", 32'({mem_en, mem_wen, mem_size, imem_wait, imem_rvalid,
                                    imem_badmem_e, dmem_wait, dmem_rvalid, dmem_badmem_e}), 0);
            chk("rst_data_buses", 32'(|{mem_addr, mem_wdata, imem_rdata, dmem_rdata}), 0);
            n_gnt = 0; n_dp = 0; n_dp_wen = 0; n_starve = 0; n_rr = 0;
            return;
        end
`ifdef VSCALE_MEM_ARB_RR_EN
        tie_i = (m_rr == 2);
`else
        tie_i = (m_starve >= SL);
`endif
        held = (m_gnt == 1 && imem_req) || (m_gnt == 2 && dmem_en);
        if (mem_wait && held)         g = m_gnt;
        else if (dmem_en && imem_req) g = tie_i ? 1 : 2;
        else if (dmem_en)             g = 2;
        else if (imem_req)            g = 1;
        else                          g = 0;
        ewen  = (g == 2) ? dmem_wen : 1'b0;
        esize = (g == 2) ? dmem_size : (g == 1) ? 3'd2 : 3'd0;
        eaddr = (g == 2) ? dmem_addr : (g == 1) ? imem_addr : '0;
        acc   = (g != 0) && !mem_wait;

        chk("mem_en", 32'(mem_en), 32'(g != 0));
        chk("mem_wen", 32'(mem_wen), 32'(ewen));
        chk("mem_size", 32'(mem_size), 32'(esize));
        chk("mem_addr", mem_addr, eaddr);
        chk("mem_wdata", mem_wdata, (m_dp == 2 && m_dp_wen) ? dmem_wdata_delayed : 32'h0);
        chk("imem_rvalid", 32'(imem_rvalid), 32'(m_dp == 1 && !mem_wait));
        chk("imem_rdata", imem_rdata, (m_dp == 1) ? mem_rdata : 32'h0);
        chk("imem_badmem_e", 32'(imem_badmem_e), 32'(m_dp == 1 && !mem_wait && mem_badmem_e));
        chk("dmem_rvalid", 32'(dmem_rvalid), 32'(m_dp == 2 && !mem_wait));
        chk("dmem_rdata", dmem_rdata, (m_dp == 2) ? mem_rdata : 32'h0);
        chk("dmem_badmem_e", 32'(dmem_badmem_e), 32'(m_dp == 2 && !mem_wait && mem_badmem_e));
        chk("imem_wait", 32'(imem_wait),
            32'((imem_req && !(acc && g == 1)) || (m_dp == 1 && mem_wait)));
        chk("dmem_wait", 32'(dmem_wait),
            32'((dmem_en && !(acc && g == 2)) || (m_dp == 2 && mem_wait)));

        n_gnt = g;
        n_dp = m_dp; n_dp_wen = m_dp_wen;
        if (acc) begin
            n_dp = g; n_dp_wen = ewen;
        end else if (!mem_wait) begin
            n_dp = 0; n_dp_wen = 0;
        end
        n_starve = m_starve;
        if (!imem_req || (acc && g == 1)) n_starve = 0;
        else if (acc && g == 2)           n_starve = (m_starve < 15) ? m_starve + 1 : 15;
        n_rr = acc ? g : m_rr;
    endtask

    task automatic sample();
        @(negedge clk);
        model_compare();
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset_n) begin
            m_gnt = 0; m_dp = 0; m_dp_wen = 0; m_starve = 0; m_rr = 0;
        end else begin
            m_gnt = n_gnt; m_dp = n_dp; m_dp_wen = n_dp_wen; m_starve = n_starve; m_rr = n_rr;
        end
        #1;
    endtask

    task automatic idle();
        imem_req = 0; dmem_en = 0; dmem_wen = 0; dmem_size = 3'd0;
        mem_wait = 0; mem_badmem_e = 0;
    endtask

    task automatic dload(input logic [XL-1:0] a);
        dmem_en = 1; dmem_wen = 0; dmem_size = 3'd2; dmem_addr = a;
    endtask

    initial begin
        int gseq[6];
        int exp_seq[6];
        int iw, wd, dw, rv;
        exp_seq = '{2, 2, 2, 2, 1, 2};

        // Reset
        idle();
        imem_req = 1; imem_addr = 32'h44; mem_wait = 1;
        sample(); advance();
        sample(); advance();
        reset_n = 1; idle();

        // 1: single fetch
        imem_req = 1; imem_addr = 32'h100;
        sample();
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_size", 32'(mem_size), 32'd2);
        advance();
        imem_req = 0; mem_rdata = 32'h1234_5678;
        sample();
        chk("t1_imem_rvalid", 32'(imem_rvalid), 1);
        chk("t1_imem_rdata", imem_rdata, 32'h1234_5678);
        chk("t1_dmem_quiet", 32'(|{dmem_wait, dmem_rvalid, dmem_rdata, dmem_badmem_e}), 0);
        advance();

        // 2: starvation limit
        imem_req = 1; imem_addr = 32'h200; dload(32'h2000);
        iw = 0;
        for (int k = 0; k < 6; k++) begin
            mem_rdata = $urandom;
            sample();
            gseq[k] = (mem_addr == 32'h2000) ? 2 : (mem_addr == 32'h200) ? 1 : 0;
            if (k < 5) iw += int'(imem_wait);
            advance();
        end
`ifndef VSCALE_MEM_ARB_RR_EN
        for (int k = 0; k < 6; k++) chk($sformatf("t2_grant%0d", k), gseq[k], exp_seq[k]);
        chk("t2_imem_wait_cycles", iw, 4);
`endif
        idle(); sample(); advance();

        // 3: store with two wait cycles in its data phase
        dmem_en = 1; dmem_wen = 1; dmem_size = 3'd2; dmem_addr = 32'h3004;
        sample();
        chk("t3_store_addr", mem_addr, 32'h3004);
        chk("t3_store_wen", 32'(mem_wen), 1);
        advance();
        wd = 0; dw = 0; rv = 0;
        dload(32'h3008); dmem_wdata_delayed = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            mem_wait = (k < 2);
            sample();
            if (k < 2) chk($sformatf("t3_frozen_addr%0d", k), mem_addr, 32'h3008);
            wd += int'(mem_wdata == 32'hDEAD_BEEF);
            dw += int'(dmem_wait);
            rv += int'(dmem_rvalid);
            advance();
        end
        chk("t3_wdata_cycles", wd, 3);
        chk("t3_dmem_wait_cycles", dw, 2);
        chk("t3_rvalid_cycles", rv, 1);
        idle();
        sample();
        chk("t3_load_wdata_zero", mem_wdata, 0);
        advance();

        // 4: fetch then load back to back
        imem_req = 1; imem_addr = 32'h400;
        sample(); advance();
        imem_req = 0; dload(32'h5000); mem_rdata = 32'hAAAA_0001;
        sample();
        chk("t4_imem_rdata", imem_rdata, 32'hAAAA_0001);
        chk("t4_dmem_addr_overlap", mem_addr, 32'h5000);
        advance();
        idle(); mem_rdata = 32'hBBBB_0002;
        sample();
        chk("t4_dmem_rvalid", 32'(dmem_rvalid), 1);
        chk("t4_dmem_rdata", dmem_rdata, 32'hBBBB_0002);
        chk("t4_imem_rdata_zero", imem_rdata, 0);
        advance();

        // 5: bus error in a data-port data phase
        dload(32'h6000);
        sample(); advance();
        idle(); mem_badmem_e = 1;
        sample();
        chk("t5_dmem_badmem", 32'(dmem_badmem_e), 1);
        chk("t5_imem_badmem", 32'(imem_badmem_e), 0);
        advance();
        sample();
        chk("t5_badmem_no_phase", 32'(dmem_badmem_e), 0);
        advance();
        idle();

        // 6: reset in the middle of a stalled data phase
        dload(32'h7000);
        sample(); advance();
        idle(); mem_wait = 1;
        sample();
        chk("t6_wait_before_rst", 32'(dmem_wait), 1);
        #1 reset_n = 0;
        #1 chk("t6_async_zero", 32'(|{mem_en, mem_wen, mem_size, mem_addr, mem_wdata, imem_wait,
                                       imem_rvalid, imem_rdata, imem_badmem_e, dmem_wait,
                                       dmem_rvalid, dmem_rdata, dmem_badmem_e}), 0);
        advance();
        sample(); advance();
        reset_n = 1; mem_wait = 0; imem_req = 1; imem_addr = 32'h800; mem_rdata = 32'h55;
        sample();
        chk("t6_first_grant", mem_addr, 32'h800);
        chk("t6_no_stale_rvalid", 32'(dmem_rvalid | imem_rvalid), 0);
        advance();
        imem_req = 0;
        sample();
        chk("t6_fetch_rvalid", 32'(imem_rvalid), 1);
        advance();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset_n            = ($urandom_range(0, 299) != 0);
            imem_req           = $urandom_range(0, 1);
            imem_addr          = $urandom;
            dmem_en            = $urandom_range(0, 1);
            dmem_wen           = $urandom_range(0, 1);
            dmem_size          = 3'($urandom_range(0, 6));
            dmem_addr          = $urandom;
            dmem_wdata_delayed = $urandom;
            mem_rdata          = $urandom;
            mem_wait           = ($urandom_range(0, 3) == 0);
            mem_badmem_e       = ($urandom_range(0, 4) == 0);
            sample();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
